// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes on both sides. Single-cycle ops return next cycle;
// MUL/MULHU run an iterative shift-add multiplier, one multiplier bit per cycle.
`timescale 1ns/1ps

module alu_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             vf,
    output logic             err
);

    localparam int unsigned     ShW     = $clog2(WIDTH);
    localparam int unsigned     CntW    = ShW + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b1000;
    localparam logic [3:0] OpSll   = 4'b0001;
    localparam logic [3:0] OpSrl   = 4'b0101;
    localparam logic [3:0] OpSra   = 4'b1101;
    localparam logic [3:0] OpSlt   = 4'b0010;
    localparam logic [3:0] OpSltu  = 4'b0011;
    localparam logic [3:0] OpAnd   = 4'b0111;
    localparam logic [3:0] OpOr    = 4'b0110;
    localparam logic [3:0] OpXor   = 4'b0100;
    localparam logic [3:0] OpMul   = 4'b1001;
    localparam logic [3:0] OpMulhu = 4'b1011;

    typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               hi_q, hi_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, vf_q, vf_d, err_q, err_d;
    logic               out_valid_q, out_valid_d;

    // Single-cycle datapath
    logic [ShW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic             slt, sltu;
    logic [WIDTH-1:0] alu_x;
    logic             alu_cf, alu_vf, alu_err, is_mul;

    assign shamt    = b[ShW-1:0];
    assign add_sum  = {1'b0, a} + {1'b0, b};
    // Carry out of a + ~b + 1 is the no-borrow flag.
    assign sub_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign slt      = $signed(a) < $signed(b);
    assign sltu     = a < b;

    always_comb begin
        alu_x   = '0;
        alu_cf  = 1'b0;
        alu_vf  = 1'b0;
        alu_err = 1'b0;
        is_mul  = 1'b0;
        case (op)
            OpAdd: begin
                alu_x  = add_sum[WIDTH-1:0];
                alu_cf = add_sum[WIDTH];
                alu_vf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                alu_x  = sub_diff[WIDTH-1:0];
                alu_cf = sub_diff[WIDTH];
                alu_vf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpSll:  alu_x = a << shamt;
            OpSrl:  alu_x = a >> shamt;
            OpSra:  alu_x = $signed(a) >>> shamt;
            OpSlt:  alu_x = {{(WIDTH-1){1'b0}}, slt};
            OpSltu: alu_x = {{(WIDTH-1){1'b0}}, sltu};
            OpAnd:  alu_x = a & b;
            OpOr:   alu_x = a | b;
            OpXor:  alu_x = a ^ b;
            OpMul, OpMulhu: begin
                if (MUL_EN) begin
                    is_mul = 1'b1;
                end else begin
                    alu_err = 1'b1;
                end
            end
            default: alu_err = 1'b1;
        endcase
    end

    // Right-shifting accumulator: product settles in acc_q after WIDTH steps.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_res;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_res = hi_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        x_d         = x_q;
        zf_d        = zf_q;
        nf_d        = nf_q;
        cf_d        = cf_q;
        vf_d        = vf_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = !out_valid_q || out_ready;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (in_valid && in_ready) begin
                    if (is_mul) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        hi_d     = (op == OpMulhu);
                        state_d  = StMul;
                    end else begin
                        x_d         = alu_x;
                        zf_d        = (alu_x == '0);
                        nf_d        = alu_x[WIDTH-1];
                        cf_d        = alu_cf;
                        vf_d        = alu_vf;
                        err_d       = alu_err;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                if (cnt_q == CntLast) begin
                    x_d         = mul_res;
                    zf_d        = (mul_res == '0);
                    nf_d        = mul_res[WIDTH-1];
                    cf_d        = 1'b0;
                    vf_d        = 1'b0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= 1'b0;
            x_q         <= '0;
            zf_q        <= 1'b0;
            nf_q        <= 1'b0;
            cf_q        <= 1'b0;
            vf_q        <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            x_q         <= x_d;
            zf_q        <= zf_d;
            nf_q        <= nf_d;
            cf_q        <= cf_d;
            vf_q        <= vf_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x         = x_q;
    assign zf        = zf_q;
    assign nf        = nf_q;
    assign cf        = cf_q;
    assign vf        = vf_q;
    assign err       = err_q;

endmodule
